// File: rtl/crossbar_ctrl_pkg.sv
// crossbar_ctrl_pkg: shared state encoding and settle-counter sizing for the crossbar sequencer
package crossbar_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, APPLY, SETTLE, SAMPLE, DONE} state_e;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES_DEF + 1);
  function automatic int settle_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/crossbar_ts_counter.sv
// crossbar_ts_counter: clearable up-counter with terminal-count compare against LAST
// Ports: clk, rst (sync, active-high), clr_i (clear, wins over inc_i), inc_i, cnt_o (count), tc_o (cnt_o==LAST)
module crossbar_ts_counter #(
  parameter int W    = 4,
  parameter int LAST = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == W'(LAST);
endmodule

// File: rtl/crossbar_controller.sv
// crossbar_controller: clear/apply/sample timing sequencer for one ReRAM crossbar integration window
// Ports: clk, rst (sync, active-high), start (sampled in IDLE), clear_acc, apply_v, sample_i, done, busy, ts_idx
// Option: CROSSBAR_CTRL_SETTLE_EN adds a SETTLE_CYCLES-long SETTLE state after each APPLY
module crossbar_controller
  import crossbar_ctrl_pkg::*;
#(
  parameter int TIMESTEPS     = 10,
  parameter int TS_WIDTH      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                clear_acc,
  output logic                apply_v,
  output logic                sample_i,
  output logic                done,
  output logic                busy,
  output logic [TS_WIDTH-1:0] ts_idx
);
  if (TIMESTEPS < 1 || TIMESTEPS > 2**TS_WIDTH || SETTLE_CYCLES < 1) begin : g_bad_params
    $error("crossbar_controller: illegal TIMESTEPS/TS_WIDTH/SETTLE_CYCLES");
  end
  state_e state_q, state_d;
  logic   ts_tc;
  logic   clear_acc_q, apply_v_q, sample_i_q, done_q, busy_q;
  // The timestep counter is held at 0 in every state outside the timestep loop.
  crossbar_ts_counter #(.W(TS_WIDTH), .LAST(TIMESTEPS - 1)) u_ts (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!(state_d inside {APPLY, SETTLE, SAMPLE})),
    .inc_i (state_q == SAMPLE && state_d == APPLY),
    .cnt_o (ts_idx),
    .tc_o  (ts_tc)
  );
`ifdef CROSSBAR_CTRL_SETTLE_EN
  logic                                st_tc;
  logic [settle_w(SETTLE_CYCLES)-1:0] st_cnt;
  crossbar_ts_counter #(.W(settle_w(SETTLE_CYCLES)), .LAST(SETTLE_CYCLES - 1)) u_settle (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_d != SETTLE),
    .inc_i (state_q == SETTLE),
    .cnt_o (st_cnt),
    .tc_o  (st_tc)
  );
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? CLEAR : IDLE;
      CLEAR:   state_d = APPLY;
`ifdef CROSSBAR_CTRL_SETTLE_EN
      APPLY:   state_d = SETTLE;
      SETTLE:  state_d = st_tc ? SAMPLE : SETTLE;
`else
      APPLY:   state_d = SAMPLE;
`endif
      SAMPLE:  state_d = ts_tc ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clear_acc_q <= 1'b0;
      apply_v_q   <= 1'b0;
      sample_i_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_acc_q <= state_d == CLEAR;
      apply_v_q   <= state_d inside {APPLY, SETTLE};
      sample_i_q  <= state_d == SAMPLE;
      done_q      <= state_d == DONE;
      busy_q      <= state_d != IDLE;
    end
  end
  assign clear_acc = clear_acc_q;
  assign apply_v   = apply_v_q;
  assign sample_i  = sample_i_q;
  assign done      = done_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_crossbar_controller.sv
// tb_crossbar_controller: table-driven scoreboard bench for crossbar_controller (TIMESTEPS=10 and TIMESTEPS=1)
module tb_crossbar_controller;
`ifdef CROSSBAR_CTRL_SETTLE_EN
  localparam int L = 4;
`else
  localparam int L = 2;
`endif
  localparam int TA      = 10;
  localparam int TB      = 1;
  localparam int RUN_A   = 2 + TA * L;
  localparam int RUN_B   = 2 + TB * L;
  localparam int SAMPLE4 = 2 + 4 * L + L - 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic a_clear, a_apply, a_sample, a_done, a_busy;
  logic b_clear, b_apply, b_sample, b_done, b_busy;
  logic [3:0] a_ts, b_ts;
  always #5 clk = ~clk;
  crossbar_controller #(.TIMESTEPS(TA), .TS_WIDTH(4), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .clear_acc(a_clear), .apply_v(a_apply),
    .sample_i(a_sample), .done(a_done), .busy(a_busy), .ts_idx(a_ts)
  );
  crossbar_controller #(.TIMESTEPS(TB), .TS_WIDTH(4), .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .clear_acc(b_clear), .apply_v(b_apply),
    .sample_i(b_sample), .done(b_done), .busy(b_busy), .ts_idx(b_ts)
  );
  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    int         cyc;
  } exp_t;
  typedef struct {
    logic rst;
    logic start;
    int   n;
    logic exp_busy;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[13];
  int n_chk = 0, n_fail = 0, ca = 0, cb = 0, tick = 0;
  // c = cycles since the start edge (0 = idle); run is CLEAR, T timesteps of L cycles, DONE.
  function automatic logic [8:0] model(input int c, input int t);
    logic [3:0] ts;
    int k, p;
    if (c == 0) return 9'h000;
    if (c == 1) return {5'b10001, 4'd0};
    if (c == 2 + t * L) return {5'b00011, 4'd0};
    k  = (c - 2) / L;
    p  = (c - 2) % L;
    ts = 4'(k);
    return {1'b0, p < L - 1, p == L - 1, 2'b01, ts};
  endfunction
  function automatic int nxt(input int c, input int t, input logic r, input logic s);
    if (r) return 0;
    if (c == 0) return s ? 1 : 0;
    if (c == 2 + t * L) return 0;
    return c + 1;
  endfunction
  task automatic chk(input string nm, input int act, input int expv, input int cyc);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask
  task automatic drive(input logic r, input logic s);
    rst   = r;
    start = s;
    ca    = nxt(ca, TA, r, s);
    cb    = nxt(cb, TB, r, s);
    tick++;
    sb.push_back('{model(ca, TA), model(cb, TB), tick});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("outs_a", int'({a_clear, a_apply, a_sample, a_done, a_busy, a_ts}), int'(e.a), e.cyc);
      chk("outs_b", int'({b_clear, b_apply, b_sample, b_done, b_busy, b_ts}), int'(e.b), e.cyc);
      chk("excl_a", int'($onehot0({a_clear, a_apply, a_sample})), 1, e.cyc);
      chk("excl_b", int'($onehot0({b_clear, b_apply, b_sample})), 1, e.cyc);
    end
  end
  initial begin
    int cyc, cnt;
    bit seen;
    tbl = '{
      '{1'b1, 1'b0, 2,             1'b0},
      '{1'b0, 1'b0, 2,             1'b0},
      '{1'b0, 1'b1, 1,             1'b1},
      '{1'b0, 1'b0, 6,             1'b1},
      '{1'b0, 1'b1, 1,             1'b1},
      '{1'b0, 1'b0, RUN_A - 5,     1'b0},
      '{1'b0, 1'b1, 1,             1'b1},
      '{1'b0, 1'b0, SAMPLE4 - 1,   1'b1},
      '{1'b1, 1'b0, 1,             1'b0},
      '{1'b0, 1'b1, 1,             1'b1},
      '{1'b0, 1'b0, RUN_A + 1,     1'b0},
      '{1'b0, 1'b1, 2 * RUN_A + 2, 1'b0},
      '{1'b0, 1'b0, 3,             1'b0}
    };
    foreach (tbl[i]) begin
      repeat (tbl[i].n) drive(tbl[i].rst, tbl[i].start);
      chk($sformatf("busy_end_%0d", i), int'(a_busy), int'(tbl[i].exp_busy), tick);
    end
    drive(1'b0, 1'b1);
    cyc  = 1;
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (a_sample) cnt++;
      if (b_done) chk("b_done_cycle", cyc, RUN_B, tick);
      if (a_done) begin
        seen = 1;
        chk("a_done_cycle", cyc, RUN_A, tick);
      end else begin
        drive(1'b0, 1'b0);
        cyc++;
      end
    end
    chk("a_done_seen", int'(seen), 1, tick);
    chk("a_sample_count", cnt, TA, tick);
    repeat (3) drive(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0, tick);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
